// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants and types for the request arbiter.
//   N_REQ        number of requesters
//   IDX_W        width of an encoded requester index
//   MAX_HOLD_DEF default maximum grant length in cycles (0 = no timeout)
//   arb_state_t  arbiter FSM states
//   idx_to_onehot helper: encoded index -> one-hot requester vector
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// -----------------------------------------------------------------------------
// arb_prio_enc
// Combinational 8-to-3 priority encoder, highest set index wins.
// Ports:
//   i_req   request vector (bit 7 highest priority)
//   o_idx   index of the highest set request bit (0 when none set)
//   o_valid high when any request bit is set
// -----------------------------------------------------------------------------
module arb_prio_enc
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Ascending scan: later (higher) indices overwrite lower ones.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (i_req[k]) begin
                o_idx   = IDX_W'(k);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// -----------------------------------------------------------------------------
// req_arbiter
// Eight-way arbiter for one shared resource. A granted owner keeps the grant
// until it releases, drops its request, or the hold limit expires; every grant
// is followed by one idle (RECOVER) cycle before the next arbitration.
//
// Build option: define ARB_RR_EN for round-robin arbitration (pointer to the
// last granted index, searched downward from last_idx-1 with last_idx lowest).
// Without it, fixed priority with index 7 highest.
//
// Parameters:
//   MAX_HOLD     maximum grant length in cycles; 0 disables the timeout
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_in       level request vector, bit k = requester k
//   release_in   current owner is done with the resource
//   grant_out    one-hot grant (registered)
//   grant_idx    encoded index of the granted requester (registered)
//   grant_valid  high while a grant is held (registered)
//   timeout_out  one-cycle pulse when a grant is revoked by the hold limit
// -----------------------------------------------------------------------------
module req_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic             release_in,
    output logic [N_REQ-1:0] grant_out,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout_out
);

    // Counter only needs to reach MAX_HOLD-1.
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_timeout;
    logic [HOLD_W-1:0] r_hold;
    logic             r_armed;

    logic [N_REQ-1:0] w_req_rot;
    logic [IDX_W-1:0] w_enc_idx;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_vld;
    logic             w_load;
    logic             w_timeout_nxt;
    logic             w_owner_req;
    logic             w_hold_done;

`ifdef ARB_RR_EN
    logic [IDX_W-1:0] r_last_idx;

    // Rotate so that req_in[last_idx-1] lands on the encoder's top bit and
    // req_in[last_idx] on its bottom bit; the index is rotated back afterwards.
    always_comb begin
        w_req_rot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_req_rot[j] = req_in[IDX_W'(j) + r_last_idx];
        end
    end

    assign w_arb_idx = w_enc_idx + r_last_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_idx <= '0;
        end else if (w_load) begin
            r_last_idx <= w_arb_idx;
        end
    end
`else
    assign w_req_rot = req_in;
    assign w_arb_idx = w_enc_idx;
`endif

    arb_prio_enc u_prio_enc (
        .i_req   (w_req_rot),
        .o_idx   (w_enc_idx),
        .o_valid (w_arb_vld)
    );

    assign w_owner_req = |(req_in & r_grant);
    assign w_hold_done = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_armed holds off arbitration for the first edge after reset.
                if (r_armed && w_arb_vld) begin
                    w_state_nxt = ST_BUSY;
                    w_load      = 1'b1;
                end
            end
            ST_BUSY: begin
                // Release wins over a coincident timeout, so no pulse then.
                if (release_in || !w_owner_req) begin
                    w_state_nxt = ST_RECOVER;
                end else if (w_hold_done) begin
                    w_state_nxt   = ST_RECOVER;
                    w_timeout_nxt = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (w_arb_vld) begin
                    w_state_nxt = ST_BUSY;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_hold    <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            r_state   <= w_state_nxt;
            r_valid   <= (w_state_nxt == ST_BUSY);
            r_timeout <= w_timeout_nxt;
            if (w_load) begin
                r_grant <= idx_to_onehot(w_arb_idx);
                r_idx   <= w_arb_idx;
                r_hold  <= '0;
            end else begin
                if (w_state_nxt != ST_BUSY) begin
                    r_grant <= '0;
                    r_idx   <= '0;
                end
                if (r_state == ST_BUSY) begin
                    r_hold <= r_hold + HOLD_W'(1);
                end
            end
        end
    end

    assign grant_out   = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = r_valid;
    assign timeout_out = r_timeout;

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum grant length in cycles; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_in  input  8  level request vector; bit k = requester k.
REQ-005 release_in  input  1  current owner finished with the shared resource.
REQ-006 grant_out  output  8  one-hot grant, registered.
REQ-007 grant_idx  output  3  encoded index of the granted requester, registered.
REQ-008 grant_valid  output  1  high while any grant is held, registered.
REQ-009 timeout_out  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-010 FSM states SHALL be IDLE, BUSY, RECOVER.
REQ-011 IDLE: if req_in != 0 at edge n, SHALL enter BUSY with the grant visible at edge n+1; otherwise stay in IDLE.
REQ-012 Arbitration SHALL use priority order only, so exactly one bit of grant_out is set in BUSY.
REQ-013 grant_idx SHALL equal the binary index of the set grant_out bit; grant_valid = (state == BUSY).
REQ-014 BUSY: the grant SHALL hold unchanged while req_in changes, including new higher-priority requests.
REQ-015 BUSY exit conditions, each to RECOVER: release_in=1; the owner's req_in bit drops; or the hold counter reaches MAX_HOLD-1 with MAX_HOLD != 0.
REQ-016 The hold counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-017 timeout_out SHALL pulse for exactly one cycle, coincident with the first RECOVER cycle, only on a timeout exit.
REQ-018 If release and timeout coincide, release_in SHALL take precedence and timeout_out stays 0.
REQ-019 RECOVER: grant_out=0 for exactly one cycle.
REQ-020 RECOVER: arbitration SHALL be evaluated, going to BUSY if req_in != 0, else to IDLE.
REQ-021 Release at edge m SHALL give no grant at m+1 and the earliest new grant at m+2.
REQ-022 release_in SHALL be ignored in IDLE and RECOVER.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, grant_out=0, grant_idx=0, grant_valid=0, timeout_out=0, hold counter=0 and RR pointer=0, even mid-grant.
REQ-024 The first grant after reset deassertion SHALL occur no earlier than the second rising edge after rst_n rises.

Configuration
REQ-025 Macro ARB_RR_EN defined: round-robin with a pointer last_idx, updated to the granted index on each BUSY entry.
REQ-026 Round-robin search order SHALL be descending from (last_idx-1) mod 8, wrapping, with last_idx lowest priority.
REQ-027 Macro ARB_RR_EN undefined: fixed priority, index 7 highest to index 0 lowest, and no pointer register.
REQ-028 With pointer=0 after reset, the first arbitration order SHALL be identical in both builds.

Structure
REQ-029 Package arb_pkg SHALL hold N_REQ=8, IDX_W=3, the state enum type and the MAX_HOLD default.
REQ-030 Sub-module arb_prio_enc SHALL be a combinational 8-to-3 highest-index-first priority encoder with a valid output.
REQ-031 Round-robin SHALL be implemented by rotating req_in before arb_prio_enc and un-rotating the index after it.

Verification
REQ-032 Reset then req_in=8'b1000_0001: next edge grant_out=8'b1000_0000, grant_idx=7, grant_valid=1.
REQ-033 While granted to 2, raise req_in[7]; after 5 cycles pulse release_in: grant stays 2 throughout, one zero cycle follows, then grant_idx=7.
REQ-034 With ARB_RR_EN, hold req_in=8'hFF and release each grant: grant_idx sequence 7,6,5,...,0,7. Without ARB_RR_EN, the sequence is 7,7,7.
REQ-035 With MAX_HOLD=4, req_in=8'b0000_0100 and no release: grant lasts 4 cycles, timeout_out=1 for one cycle, then re-grant to 2.
REQ-036 Drop rst_n during BUSY: outputs zero asynchronously; after release, req_in=8'b0000_0111 grants index 2.
REQ-037 Owner drops its req bit while another request is pending: the RECOVER cycle occurs, then the grant goes to the pending requester, with timeout_out=0.
